// File: rtl/centering_pkg.sv
// Shared types and helpers for the FastICA centering front-end.
package cen_pkg;
  localparam int CEN_DATA_W = 26;

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, MEAN, SUB, FLUSH, DONE} cen_state_e;

  // Clamp a DATA_W+1 signed value into the DATA_W signed range.
  function automatic logic signed [CEN_DATA_W-1:0] sat_narrow(input logic signed [CEN_DATA_W:0] d);
    if (d[CEN_DATA_W] != d[CEN_DATA_W-1])
      return d[CEN_DATA_W] ? {1'b1, {(CEN_DATA_W-1){1'b0}}} : {1'b0, {(CEN_DATA_W-1){1'b1}}};
    return d[CEN_DATA_W-1:0];
  endfunction
endpackage

// File: rtl/centering_if.sv
// Sample-memory read port, raw/centered sample streams and status of the centering stage.
interface centering_if import cen_pkg::*; #(
  parameter int DATA_W = CEN_DATA_W,
  parameter int LOG2_N = 10
);
  logic                     GO_cen;
  logic                     RD_en;
  logic        [LOG2_N-1:0] RD_addr;
  logic signed [DATA_W-1:0] X1, X2, X3, X4;
  logic signed [DATA_W-1:0] Xcen1, Xcen2, Xcen3, Xcen4;
  logic                     Xcen_valid;
  logic signed [DATA_W-1:0] M1, M2, M3, M4;
  logic                     Cen_busy;
  logic                     Cen_done;

  modport master (
    input  GO_cen, X1, X2, X3, X4,
    output RD_en, RD_addr, Xcen1, Xcen2, Xcen3, Xcen4, Xcen_valid,
           M1, M2, M3, M4, Cen_busy, Cen_done
  );
  modport slave (
    output GO_cen, X1, X2, X3, X4,
    input  RD_en, RD_addr, Xcen1, Xcen2, Xcen3, Xcen4, Xcen_valid,
           M1, M2, M3, M4, Cen_busy, Cen_done
  );
endinterface

// File: rtl/centering_lane.sv
// One channel: sum accumulator, mean register, saturating subtract and Xcen register.
module centering_lane import cen_pkg::*; #(
  parameter int DATA_W = CEN_DATA_W,
  parameter int LOG2_N = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     mean_en,
  input  logic                     sub_en,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] m,
  output logic signed [DATA_W-1:0] xcen
);
  localparam int ACC_W = DATA_W + LOG2_N;

  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W:0]   diff;

  assign diff = {x[DATA_W-1], x} - {m[DATA_W-1], m};

  // Dropping the low LOG2_N bits of the sum is the floor divide by N.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      m    <= '0;
      xcen <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (acc_en) acc <= acc + {{LOG2_N{x[DATA_W-1]}}, x};
      if (mean_en)     m    <= acc[ACC_W-1:LOG2_N];
      if (sub_en)      xcen <= sat_narrow(diff);
    end
  end
endmodule

// File: rtl/centering.sv
// Two-pass centering: pass 1 forms channel means, pass 2 streams mean-subtracted samples.
module centering import cen_pkg::*; #(
  parameter int DATA_W    = CEN_DATA_W,
  parameter int LOG2_N    = 10,
  parameter int N_SAMPLES = 1024
) (
  input logic         CLK,
  input logic         RST,
  centering_if.master bus
);
  localparam int NUM_LANES = 4;

  cen_state_e                        state, state_nxt;
  logic [LOG2_N-1:0]                 cnt, cnt_nxt;
  logic                              clr, last, acc_vld, mean_en;
  logic [1:0]                        vld_pipe;
  logic [NUM_LANES-1:0][DATA_W-1:0]  x_arr, m_arr, xcen_arr;

  assign last = (cnt == LOG2_N'(N_SAMPLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_vld  <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc_vld  <= (state == ACC);
      vld_pipe <= {vld_pipe[0], state == SUB};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.GO_cen) begin
          clr       = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = MEAN;
      MEAN:  state_nxt = SUB;
      SUB: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = FLUSH;
      end
      // Two cycles let the final reads land and reach the Xcen registers.
      FLUSH: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LOG2_N'(1)) state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.RD_en      = (state == ACC) || (state == SUB);
  assign bus.RD_addr    = bus.RD_en ? cnt : '0;
  assign bus.Cen_busy   = (state != IDLE) && (state != DONE);
  assign bus.Cen_done   = (state == DONE);
  assign bus.Xcen_valid = vld_pipe[1];
  assign mean_en        = (state == MEAN);

  assign x_arr = {bus.X4, bus.X3, bus.X2, bus.X1};

  centering_lane #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_lane [NUM_LANES-1:0] (
    .clk     (CLK),
    .rst     (RST),
    .clr     (clr),
    .acc_en  (acc_vld),
    .mean_en (mean_en),
    .sub_en  (vld_pipe[0]),
    .x       (x_arr),
    .m       (m_arr),
    .xcen    (xcen_arr)
  );

  assign bus.M1    = m_arr[0];
  assign bus.M2    = m_arr[1];
  assign bus.M3    = m_arr[2];
  assign bus.M4    = m_arr[3];
  assign bus.Xcen1 = xcen_arr[0];
  assign bus.Xcen2 = xcen_arr[1];
  assign bus.Xcen3 = xcen_arr[2];
  assign bus.Xcen4 = xcen_arr[3];
endmodule

// File: tb/tb_centering.sv
// Scoreboard bench for centering with a small-block reference model and a 1-cycle sample memory.
module tb_centering;
  import cen_pkg::*;

  localparam int     DW   = 26;
  localparam int     LN   = 2;
  localparam int     N    = 4;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  typedef struct {
    longint xc[4];
    longint m[4];
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  centering_if #(.DATA_W(DW), .LOG2_N(LN)) bus ();
  centering #(.DATA_W(DW), .LOG2_N(LN), .N_SAMPLES(N)) dut (.CLK(clk), .RST(rst), .bus(bus));

  logic signed [DW-1:0] mem [4][N];
  exp_t   q[$];
  int     total = 0, passed = 0, done_cnt = 0, exp_done = 0;
  longint last_m[4];

  always @(posedge clk) begin
    if (rst) begin
      bus.X1 <= '0; bus.X2 <= '0; bus.X3 <= '0; bus.X4 <= '0;
    end else if (bus.RD_en) begin
      bus.X1 <= mem[0][bus.RD_addr];
      bus.X2 <= mem[1][bus.RD_addr];
      bus.X3 <= mem[2][bus.RD_addr];
      bus.X4 <= mem[3][bus.RD_addr];
    end
  end

  task automatic check(string name, longint act, longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic longint floor_div(longint s);
    longint r;
    r = s / N;
    if ((s % N != 0) && (s < 0)) r = r - 1;
    return r;
  endfunction

  function automatic longint clamp(longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic push_expect();
    exp_t   e[N];
    longint s;
    for (int ch = 0; ch < 4; ch++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += longint'(mem[ch][k]);
      last_m[ch] = floor_div(s);
      for (int k = 0; k < N; k++) begin
        e[k].m[ch]  = last_m[ch];
        e[k].xc[ch] = clamp(longint'(mem[ch][k]) - last_m[ch]);
      end
    end
    for (int k = 0; k < N; k++) q.push_back(e[k]);
    exp_done++;
  endtask

  task automatic fill_rand();
    longint v;
    for (int ch = 0; ch < 4; ch++)
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0:       v = longint'($urandom_range(0, 200)) - 100;
          1:       v = MAXV;
          2:       v = MINV;
          default: v = longint'($urandom);
        endcase
        mem[ch][k] = v[DW-1:0];
      end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.Cen_done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ctl"}, {bus.RD_en, bus.RD_addr, bus.Xcen_valid, bus.Cen_busy, bus.Cen_done}, 0);
    check({tag, "_data"}, (|{bus.Xcen1, bus.Xcen2, bus.Xcen3, bus.Xcen4,
                            bus.M1, bus.M2, bus.M3, bus.M4}) ? 1 : 0, 0);
  endtask

  task automatic check_means(string tag);
    longint act[4];
    act[0] = bus.M1; act[1] = bus.M2; act[2] = bus.M3; act[3] = bus.M4;
    for (int i = 0; i < 4; i++) check($sformatf("%s_m%0d", tag, i + 1), act[i], last_m[i]);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t   e;
    longint ax[4], am[4];
    if (!rst && bus.Xcen_valid) begin
      if (q.size() == 0) check("xcen_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        ax[0] = bus.Xcen1; ax[1] = bus.Xcen2; ax[2] = bus.Xcen3; ax[3] = bus.Xcen4;
        am[0] = bus.M1;    am[1] = bus.M2;    am[2] = bus.M3;    am[3] = bus.M4;
        for (int i = 0; i < 4; i++) begin
          check($sformatf("xcen%0d", i + 1), ax[i], e.xc[i]);
          check($sformatf("mean%0d", i + 1), am[i], e.m[i]);
        end
      end
    end
    if (!rst && bus.Cen_done) done_cnt++;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drive
    int            cyc, d0;
    logic          e_rd, e_v, e_busy, e_dn;
    logic [LN-1:0] e_addr;
    logic [5:0]    req;
    bus.GO_cen = 1'b0;
    for (int ch = 0; ch < 4; ch++)
      for (int k = 0; k < N; k++) mem[ch][k] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed block with per-cycle timing check
    for (int k = 0; k < N; k++) begin
      mem[0][k] = DW'(k + 1);
      mem[1][k] = -DW'(k + 1);
      mem[2][k] = (k == N - 1) ? MINV[DW-1:0] : MAXV[DW-1:0];
      mem[3][k] = DW'($urandom);
    end
    push_expect();
    bus.GO_cen = 1'b1;
    @(negedge clk);
    bus.GO_cen = 1'b0;
    for (int c = 1; c <= 2 * N + 6; c++) begin
      if (c > 1) @(negedge clk);
      e_rd   = ((c >= 1) && (c <= N)) || ((c >= N + 3) && (c <= 2 * N + 2));
      e_addr = !e_rd ? '0 : (c <= N) ? LN'(c - 1) : LN'(c - N - 3);
      e_v    = (c >= N + 5) && (c <= 2 * N + 4);
      e_busy = (c >= 1) && (c <= 2 * N + 4);
      e_dn   = (c == 2 * N + 5);
      req    = {e_rd, e_addr, e_v, e_busy, e_dn};
      check($sformatf("timing_c%0d", c),
            {bus.RD_en, bus.RD_addr, bus.Xcen_valid, bus.Cen_busy, bus.Cen_done}, req);
    end
    check("dir_m1", bus.M1, 2);
    check("dir_m2", bus.M2, -3);
    check("dir_m3", bus.M3, (longint'(1) <<< 24) - 1);
    check("dir_xcen3_hold", bus.Xcen3, MINV);

    // GO during DRAIN ignored, then reset mid-block aborts
    fill_rand();
    bus.GO_cen = 1'b1;
    @(negedge clk);
    bus.GO_cen = 1'b0;
    repeat (4) @(negedge clk);
    bus.GO_cen = 1'b1;
    @(negedge clk);
    check("go_ignored_c6", {bus.Cen_busy, bus.RD_en}, 2'b10);
    bus.GO_cen = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (2 * N + 8) @(negedge clk);
    check("abort_no_done", done_cnt, d0);

    // Fresh block, GO pulsed mid-SUB must not restart
    fill_rand();
    push_expect();
    bus.GO_cen = 1'b1;
    @(negedge clk);
    bus.GO_cen = 1'b0;
    repeat (7) @(negedge clk);
    bus.GO_cen = 1'b1;
    @(negedge clk);
    bus.GO_cen = 1'b0;
    wait_done(100, cyc);
    repeat (3) @(negedge clk);
    check("no_restart_busy", bus.Cen_busy, 0);
    check_means("fresh");

    // Back-to-back with GO held high
    fill_rand();
    push_expect();
    bus.GO_cen = 1'b1;
    wait_done(100, cyc);
    fill_rand();
    push_expect();
    wait_done(100, cyc);
    bus.GO_cen = 1'b0;
    check("b2b_gap", cyc, 2 * N + 6);
    @(negedge clk);
    check_means("b2b");

    for (int b = 0; b < 3; b++) begin
      fill_rand();
      push_expect();
      bus.GO_cen = 1'b1;
      @(negedge clk);
      bus.GO_cen = 1'b0;
      wait_done(100, cyc);
      check($sformatf("rand%0d_latency", b), cyc, 2 * N + 4);
      @(negedge clk);
      check_means($sformatf("rand%0d", b));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("done_count", done_cnt, exp_done);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
